aig_seq_eval: RTL and testbench



---
 rtl/aig_eval_pkg.sv | 27 ++
 rtl/aig_seq_eval_table.sv | 36 +++
 rtl/aig_seq_eval.sv | 144 ++++++++++++++
 tb/tb_aig_seq_eval.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aig_eval_pkg.sv
// Shared types and literal helpers for the sequential AIG evaluator.
// The lit_t width follows the default NUM_IN / MAX_NODES sizing below.
package aig_eval_pkg;
  localparam int unsigned DEF_NUM_IN    = 4;
  localparam int unsigned DEF_MAX_NODES = 16;
  localparam int unsigned NV_W          = $clog2(1 + DEF_NUM_IN + DEF_MAX_NODES);
  localparam int unsigned LIT_W         = NV_W + 1;

  typedef logic [LIT_W-1:0] lit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam lit_t LIT_CONST0 = lit_t'(0);
  localparam lit_t LIT_CONST1 = lit_t'(1);

  function automatic logic [NV_W-1:0] lit_var(input lit_t l);
    return l[LIT_W-1:1];
  endfunction

  function automatic logic lit_neg(input lit_t l);
    return l[0];
  endfunction
endpackage

// File: rtl/aig_seq_eval_table.sv
// Node table: MAX_NODES entries of two fanin literals, synchronous write,
// asynchronous read at the node currently being evaluated.
module aig_node_table
  import aig_eval_pkg::*;
#(
  parameter int unsigned MAX_NODES = DEF_MAX_NODES,
  parameter int unsigned IDX_W     = $clog2(MAX_NODES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  lit_t             i_wlit0,
  input  lit_t             i_wlit1,
  input  logic [IDX_W-1:0] i_raddr,
  output lit_t             o_rlit0,
  output lit_t             o_rlit1
);
  lit_t r_lit0 [MAX_NODES];
  lit_t r_lit1 [MAX_NODES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_NODES; i++) begin
        r_lit0[i] <= LIT_CONST0;
        r_lit1[i] <= LIT_CONST0;
      end
    end else if (i_we) begin
      r_lit0[i_waddr] <= i_wlit0;
      r_lit1[i_waddr] <= i_wlit1;
    end
  end

  assign o_rlit0 = r_lit0[i_raddr];
  assign o_rlit1 = r_lit1[i_raddr];
endmodule

// File: rtl/aig_seq_eval.sv
// Sequential AIG evaluator: one AND node per clock over a run-time-loaded
// node table, fed by a valid/ready input stream and drained by out_ready.
module aig_seq_eval
  import aig_eval_pkg::*;
#(
  parameter int unsigned NUM_IN    = DEF_NUM_IN,
  parameter int unsigned MAX_NODES = DEF_MAX_NODES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(MAX_NODES)-1:0] cfg_addr,
  input  lit_t                         cfg_lit0,
  input  lit_t                         cfg_lit1,
  input  logic [$clog2(MAX_NODES):0]   cfg_num_nodes,
  input  lit_t                         cfg_out_lit,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_IN-1:0]            in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_y,
  output logic                         busy
);
  localparam int unsigned IDX_W = $clog2(MAX_NODES);
  localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(MAX_NODES);

  state_e               r_state;
  logic                 r_in_ready, r_out_valid, r_busy, r_y;
  logic [IDX_W-1:0]     r_k;
  logic [IDX_W:0]       r_num;
  logic [NUM_IN-1:0]    r_x;
  lit_t                 r_out_lit;
  logic [MAX_NODES-1:0] r_val;

  lit_t                 w_lit0, w_lit1;
  logic                 w_we, w_node, w_last;
  logic [IDX_W:0]       w_num_cl;
  logic [MAX_NODES-1:0] w_val_next;

  // Unevaluated nodes and vars past the last node read as the cleared value 0.
  function automatic logic lit_value(input lit_t lit, input logic [NUM_IN-1:0] x,
                                     input logic [MAX_NODES-1:0] vals);
    int unsigned v;
    logic        b;
    v = 32'(lit_var(lit));
    b = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++)
      if (v == i + 1) b = x[i];
    for (int unsigned i = 0; i < MAX_NODES; i++)
      if (v == NUM_IN + 1 + i) b = vals[i];
    return b ^ lit_neg(lit);
  endfunction

  assign w_we = cfg_we & (r_state == IDLE);

  aig_node_table #(
    .MAX_NODES(MAX_NODES),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we),
    .i_waddr(cfg_addr),
    .i_wlit0(cfg_lit0),
    .i_wlit1(cfg_lit1),
    .i_raddr(r_k),
    .o_rlit0(w_lit0),
    .o_rlit1(w_lit1)
  );

  always_comb begin
    w_num_cl        = (cfg_num_nodes > NUM_MAX) ? NUM_MAX : cfg_num_nodes;
    w_node          = lit_value(w_lit0, r_x, r_val) & lit_value(w_lit1, r_x, r_val);
    w_val_next      = r_val;
    w_val_next[r_k] = w_node;
    w_last          = ({1'b0, r_k} == (r_num - (IDX_W+1)'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_y         <= 1'b0;
      r_k         <= '0;
      r_num       <= '0;
      r_x         <= '0;
      r_out_lit   <= LIT_CONST0;
      r_val       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x        <= in_x;
            r_out_lit  <= cfg_out_lit;
            r_num      <= w_num_cl;
            r_val      <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_num_cl == '0) begin
              // Empty graph: output literal sees only inputs and constants.
              r_y         <= lit_value(cfg_out_lit, in_x, '0);
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= EVAL;
            end
          end
        end
        EVAL: begin
          r_val <= w_val_next;
          r_k   <= r_k + IDX_W'(1);
          if (w_last) begin
            r_y         <= lit_value(r_out_lit, r_x, w_val_next);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_y;
  assign busy      = r_busy;
endmodule

// File: tb/tb_aig_seq_eval.sv
// Bench for aig_seq_eval: transaction-level reference model plus directed
// literal checks and a randomized stream phase.
module tb_aig_seq_eval;
  import aig_eval_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  lit_t       cfg_lit0 = '0, cfg_lit1 = '0;
  logic [4:0] cfg_num_nodes = '0;
  lit_t       cfg_out_lit = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_x = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_y;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  aig_seq_eval #(.NUM_IN(4), .MAX_NODES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_lit0(cfg_lit0), .cfg_lit1(cfg_lit1), .cfg_num_nodes(cfg_num_nodes),
    .cfg_out_lit(cfg_out_lit), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table contents and a per-transaction outcome/countdown.
  bit [5:0] m_l0 [16];
  bit [5:0] m_l1 [16];
  bit       m_busy, m_valid, m_y;
  int       m_cnt;

  function automatic bit m_litval(bit [5:0] lit, bit [3:0] x, bit [15:0] vals);
    int v;
    bit b;
    v = int'(lit >> 1);
    b = 1'b0;
    if (v >= 1 && v <= 4) b = x[v-1];
    else if (v >= 5 && v <= 20) b = vals[v-5];
    return b ^ lit[0];
  endfunction

  function automatic bit m_eval(int n, bit [5:0] outlit, bit [3:0] x);
    bit [15:0] vals;
    vals = '0;
    for (int k = 0; k < n; k++)
      vals[k] = m_litval(m_l0[k], x, vals) & m_litval(m_l1[k], x, vals);
    return m_litval(outlit, x, vals);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_l0[i] = '0;
      m_l1[i] = '0;
    end
    m_busy = 1'b0; m_valid = 1'b0; m_y = 1'b0; m_cnt = 0;
  endtask

  task automatic m_step();
    int n;
    if (!m_busy) begin
      if (cfg_we) begin
        m_l0[cfg_addr] = cfg_lit0;
        m_l1[cfg_addr] = cfg_lit1;
      end
      if (in_valid) begin
        n = (cfg_num_nodes > 5'd16) ? 16 : int'(cfg_num_nodes);
        m_y     = m_eval(n, cfg_out_lit, in_x);
        m_busy  = 1'b1;
        m_cnt   = n;
        m_valid = (n == 0);
      end
    end else if (!m_valid) begin
      m_cnt--;
      if (m_cnt == 0) m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        chk("in_ready", in_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) chk("out_y", out_y, m_y);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic cfg_write(input logic [3:0] a, input lit_t l0, input lit_t l1);
    cfg_we = 1'b1; cfg_addr = a; cfg_lit0 = l0; cfg_lit1 = l1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic run_vec(input logic [3:0] x, input logic [4:0] num, input lit_t ol,
                         output logic y, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1; in_x = x; cfg_num_nodes = num; cfg_out_lit = ol;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    y = out_y;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic load_xor();
    cfg_write(4'd0, 6'd2, 6'd5);    // x0 & ~x1
    cfg_write(4'd1, 6'd3, 6'd4);    // ~x0 & x1
    cfg_write(4'd2, 6'd11, 6'd13);  // neither: xnor
  endtask

  initial begin
    logic       y;
    int         lat;
    logic [3:0] xi;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);

    // Single AND node
    cfg_write(4'd0, 6'd2, 6'd5);
    chk("model_and", m_eval(1, 6'd10, 4'b0001), 1);
    run_vec(4'b0001, 5'd1, 6'd10, y, lat);
    chk("and_0001", y, 1);
    chk("and_lat", lat, 2);
    run_vec(4'b0011, 5'd1, 6'd10, y, lat);
    chk("and_0011", y, 0);

    // XOR via three nodes, negated output
    load_xor();
    chk("model_xor", m_eval(3, 6'd15, 4'b0010), 1);
    for (int i = 0; i < 16; i++) begin
      xi = 4'(i);
      run_vec(xi, 5'd3, 6'd15, y, lat);
      chk("xor_y", y, xi[0] ^ xi[1]);
      chk("xor_lat", lat, 4);
    end

    // Zero nodes: constant outputs
    run_vec(4'b1010, 5'd0, LIT_CONST1, y, lat);
    chk("const1_y", y, 1);
    chk("const1_lat", lat, 1);
    run_vec(4'b1111, 5'd0, LIT_CONST0, y, lat);
    chk("const0_y", y, 0);

    // Backpressure, with a write attempted while busy
    in_valid = 1'b1; in_x = 4'b0001; cfg_num_nodes = 5'd3; cfg_out_lit = 6'd15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_lit0 = '0; cfg_lit1 = '0;
      end else begin
        cfg_we = 1'b0;
      end
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_y", out_y, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_vec(4'b0011, 5'd3, 6'd15, y, lat);
    chk("bp_table_kept", y, 0);

    // Forward reference: node0 reads node1 before it is evaluated
    cfg_write(4'd0, 6'd12, 6'd2);
    cfg_write(4'd1, 6'd2, 6'd2);
    chk("model_fwd", m_eval(2, 6'd10, 4'b0001), 0);
    run_vec(4'b0001, 5'd2, 6'd10, y, lat);
    chk("fwd_node0", y, 0);
    run_vec(4'b0001, 5'd2, 6'd12, y, lat);
    chk("fwd_node1", y, 1);

    // Write coincident with accept is used by that evaluation
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_lit0 = 6'd2; cfg_lit1 = 6'd2;
    in_valid = 1'b1; in_x = 4'b0001; cfg_num_nodes = 5'd1; cfg_out_lit = 6'd10;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    wait_valid(lat);
    chk("coincident_y", out_y, 1);
    chk("coincident_lat", lat, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Oversized node count clamps; out-of-range var reads 0
    cfg_write(4'd15, 6'd2, 6'd2);
    run_vec(4'b0001, 5'd31, 6'd40, y, lat);
    chk("clamp_y", y, 1);
    chk("clamp_lat", lat, 17);
    run_vec(4'b0001, 5'd31, 6'd43, y, lat);
    chk("oor_var_y", y, 1);

    // Reset during EVAL aborts with outputs cleared at once
    load_xor();
    run_vec(4'b0001, 5'd3, 6'd15, y, lat);
    chk("pre_rst_y", y, 1);
    in_valid = 1'b1; in_x = 4'b0001; cfg_num_nodes = 5'd3; cfg_out_lit = 6'd15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_y", out_y, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_out", out_valid, 0);

    // Randomized stream against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_x      = 4'($urandom);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = 4'($urandom);
      cfg_lit0  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 41));
      cfg_lit1  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 41));
      cfg_num_nodes = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
      cfg_out_lit   = 6'($urandom_range(0, 43));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
